// File: rtl/echo_delay.sv
// Circular-buffer echo: a sample-count delay line with a stale-data mask, a saturating
// dry+echo mix and an optional recirculating feedback write path.
module echo_delay #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int MIX_SHIFT     = 1,
    parameter int FB_SHIFT      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic                     feedback_en,
    input  logic [DATA_WIDTH-1:0]    mic_signal,
    output logic [DATA_WIDTH-1:0]    delayed_signal,
    output logic [DATA_WIDTH-1:0]    echo_out,
    output logic                     out_valid
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0]    ram [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [ADDRESS_WIDTH:0]   fill;
    logic [DATA_WIDTH-1:0]    tap;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [DATA_WIDTH-1:0]    mix;

    function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
    endfunction

    assign rd_addr = wr_ptr - offset;

    // Locations not yet written since reset read as silence rather than stale RAM.
    always_comb begin
        tap = '0;
        if (offset == '0) begin
            tap = mic_signal;
        end else if (fill < {1'b0, offset}) begin
            tap = '0;
        end else begin
            tap = ram[rd_addr];
        end
    end

    assign wr_data = (feedback_en && offset != '0) ? sat_add(mic_signal, tap >> FB_SHIFT)
                                                   : mic_signal;
    assign mix     = sat_add(mic_signal, tap >> MIX_SHIFT);

    always_ff @(posedge clk) begin
        if (en && !rst) begin
            ram[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            fill           <= '0;
            delayed_signal <= '0;
            echo_out       <= '0;
            out_valid      <= 1'b0;
        end else if (en) begin
            wr_ptr         <= wr_ptr + 1'b1;
            if (!fill[ADDRESS_WIDTH]) begin
                fill <= fill + 1'b1;
            end
            delayed_signal <= tap;
            echo_out       <= mix;
            out_valid      <= 1'b1;
        end else begin
            out_valid      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_echo_delay.sv
// Bench for echo_delay: directed scenarios plus random strobes, offsets and feedback,
// all scored against a sample-history reference model.
module tb_echo_delay;
    localparam int AW        = 9;
    localparam int DW        = 8;
    localparam int DEPTH     = 512;
    localparam int MIX_SHIFT = 1;
    localparam int FB_SHIFT  = 1;
    localparam int MAXV      = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [AW-1:0] offset = '0;
    logic          feedback_en = 1'b0;
    logic [DW-1:0] mic_signal = '0;
    logic [DW-1:0] delayed_signal;
    logic [DW-1:0] echo_out;
    logic          out_valid;

    echo_delay #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MIX_SHIFT(MIX_SHIFT), .FB_SHIFT(FB_SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .offset(offset), .feedback_en(feedback_en),
        .mic_signal(mic_signal), .delayed_signal(delayed_signal), .echo_out(echo_out),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: every value written since reset, indexed by sample number.
    int            hist[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_eq[$];
    int            exp_v = 0;
    int            last_d = 0;
    int            last_e = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic model_step(input int r, input int e, input int x, input int off, input int fb);
        int tap;
        int n;
        if (r != 0) begin
            hist.delete();
            exp_q.delete();
            exp_eq.delete();
            exp_v  = 0;
            last_d = 0;
            last_e = 0;
        end else if (e != 0) begin
            n = hist.size();
            if (off == 0)      tap = x;
            else if (n < off)  tap = 0;
            else               tap = hist[n - off];
            if (fb != 0 && off != 0) hist.push_back(sat(x + (tap >> FB_SHIFT)));
            else                     hist.push_back(x);
            last_d = tap;
            last_e = sat(x + (tap >> MIX_SHIFT));
            exp_q.push_back(last_d[DW-1:0]);
            exp_eq.push_back(last_e[DW-1:0]);
            exp_v = 1;
        end else begin
            exp_v = 0;
        end
    endtask

    // One clock: drive inputs, advance the model, then sample 1 time unit after the edge.
    task automatic apply(input int r, input int e, input int x, input int off, input int fb);
        logic [DW-1:0] d;
        logic [DW-1:0] ee;
        rst         = (r != 0);
        en          = (e != 0);
        mic_signal  = x[DW-1:0];
        offset      = off[AW-1:0];
        feedback_en = (fb != 0);
        model_step(r, e, x, off, fb);
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_valid}, exp_v);
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                d  = exp_q.pop_front();
                ee = exp_eq.pop_front();
                check("delayed_signal", {24'd0, delayed_signal}, {24'd0, d});
                check("echo_out", {24'd0, echo_out}, {24'd0, ee});
            end
        end else begin
            check("delayed_hold", {24'd0, delayed_signal}, last_d);
            check("echo_hold", {24'd0, echo_out}, last_e);
        end
    endtask

    int fb4[9] = '{0, 0, 128, 0, 64, 0, 32, 0, 16};

    initial begin
        int off_r;
        int fb_r;
        // Reset values
        apply(1, 0, 0, 0, 0);
        check("reset_delayed", {24'd0, delayed_signal}, 0);
        check("reset_echo", {24'd0, echo_out}, 0);
        check("reset_valid", {31'd0, out_valid}, 0);

        // Basic delay of 4 samples
        for (int k = 0; k < 12; k++) begin
            apply(0, 1, k + 1, 4, 0);
            check("basic_delay", {24'd0, delayed_signal}, (k < 4) ? 0 : k - 3);
        end

        // Strobe gaps: delay counted in samples, outputs hold between strobes
        apply(1, 0, 0, 3, 0);
        for (int k = 0; k < 5; k++) begin
            apply(0, 1, 10 * (k + 1), 3, 0);
            check("gap_delay", {24'd0, delayed_signal}, (k < 3) ? 0 : 10 * (k - 2));
            apply(0, 0, 77, 3, 0);
            apply(0, 0, 99, 3, 0);
        end

        // Mix saturation then bypass
        apply(1, 0, 0, 1, 0);
        apply(0, 1, 200, 1, 0);
        apply(0, 1, 200, 1, 0);
        check("mix_saturate", {24'd0, echo_out}, 255);
        apply(0, 1, 60, 0, 0);
        check("bypass_delayed", {24'd0, delayed_signal}, 60);
        check("bypass_echo", {24'd0, echo_out}, 90);

        // Recirculating feedback
        apply(1, 0, 0, 2, 1);
        for (int k = 0; k < 9; k++) begin
            apply(0, 1, (k == 0) ? 128 : 0, 2, 1);
            check("feedback_tap", {24'd0, delayed_signal}, fb4[k]);
        end

        // Maximum delay across the pointer wrap
        apply(1, 0, 0, 511, 0);
        for (int n = 0; n < 600; n++) begin
            apply(0, 1, n % 256, 511, 0);
            check("max_delay", {24'd0, delayed_signal}, (n < 511) ? 0 : (n - 511) % 256);
        end

        // Mid-run reset hides stale RAM
        for (int n = 0; n < 600; n++) apply(0, 1, $urandom_range(0, 255), 8, 0);
        apply(1, 1, 33, 8, 0);
        check("midrst_valid", {31'd0, out_valid}, 0);
        check("midrst_delayed", {24'd0, delayed_signal}, 0);
        for (int k = 0; k < 12; k++) begin
            apply(0, 1, 100 + k, 8, 0);
            check("post_reset", {24'd0, delayed_signal}, (k < 8) ? 0 : 92 + k);
        end

        // Random strobes, offsets, feedback and occasional resets
        off_r = 5;
        fb_r  = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       off_r = 0;
                    1:       off_r = $urandom_range(1, 8);
                    2:       off_r = $urandom_range(1, 40);
                    default: off_r = $urandom_range(1, DEPTH - 1);
                endcase
            end
            if ($urandom_range(0, 59) == 0) fb_r = $urandom_range(0, 1);
            apply(($urandom_range(0, 499) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  $urandom_range(0, 255), off_r, fb_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
